// File: rtl/ecb_dec.sv
// AES-128 single-block inverse cipher, iterative, one round per clock (22-edge latency).
// Define ECB_DEC_MASK_OUT_EN to hide intermediate round states from plain_text.

module ecb_dec_col (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, m9, m11, m13, m14;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      logic [7:0] x2, x4, x8;
      a[r]   = col[31-8*r -: 8];
      x2     = xt(a[r]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[r]  = x8 ^ a[r];
      m11[r] = x8 ^ x2 ^ a[r];
      m13[r] = x8 ^ x4 ^ a[r];
      m14[r] = x8 ^ x4 ^ x2;
    end
  end

  assign mixed = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                  m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                  m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                  m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
endmodule

module ecb_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic [127:0] plain_text,
  output logic         done
);
  localparam int NUM_LANES = 4;

  // Byte 0 of each table is the leftmost byte; element [255] holds entry 0.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[~x];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [2:0] {LOAD, KEYEXP, INIT, ROUND, FINAL, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;

  logic [127:0] isb, ark, mix;
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  i0, i1, i2, i3;
  logic [31:0]  rcw;

  // InvShiftRows folded into the byte select, then InvSubBytes per byte.
  for (genvar c = 0; c < NUM_LANES; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isb[127-8*(4*c+r) -: 8] =
        inv_sbox(st_q[127-8*(4*((c-r+4)%4)+r) -: 8]);
    end
    ecb_dec_col u_col (
      .col   (ark[127-32*c -: 32]),
      .mixed (mix[127-32*c -: 32])
    );
  end

  assign ark = isb ^ key_q;

  assign {kw0, kw1, kw2, kw3} = key_q;
  assign rcw = {rcon(rnd_q), 24'h0};

  // Forward schedule step: rk_{n-1} -> rk_n
  assign f0 = kw0 ^ sub_rot(kw3) ^ rcw;
  assign f1 = kw1 ^ f0;
  assign f2 = kw2 ^ f1;
  assign f3 = kw3 ^ f2;

  // Inverse schedule step: rk_n -> rk_{n-1}; the last word must be recovered first
  assign i3 = kw3 ^ kw2;
  assign i2 = kw2 ^ kw1;
  assign i1 = kw1 ^ kw0;
  assign i0 = kw0 ^ sub_rot(i3) ^ rcw;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    done_d  = done_q;
    case (state_q)
      LOAD: begin
        st_d    = cipher_text;
        key_d   = key;
        rnd_d   = 4'd1;
        state_d = KEYEXP;
      end
      KEYEXP: begin
        key_d = {f0, f1, f2, f3};
        if (rnd_q == 4'd10) state_d = INIT;
        else                 rnd_d  = rnd_q + 4'd1;
      end
      INIT: begin
        st_d    = st_q ^ key_q;
        key_d   = {i0, i1, i2, i3};
        rnd_d   = rnd_q - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        st_d  = mix;
        key_d = {i0, i1, i2, i3};
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        st_d    = ark;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: ;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      rnd_q   <= 4'd0;
      st_q    <= 128'h0;
      key_q   <= 128'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

`ifdef ECB_DEC_MASK_OUT_EN
  logic [127:0] pt_q;

  always_ff @(posedge clk) begin
    if (rst)                   pt_q <= 128'h0;
    else if (state_q == FINAL) pt_q <= ark;
  end

  assign plain_text = pt_q;
`else
  assign plain_text = st_q;
`endif

  assign done = done_q;
endmodule

// File: tb/tb_ecb_dec.sv
// Bench for ecb_dec: FIPS-197 vectors, abort/stability cases, and random blocks
// whose ciphertext comes from a forward AES-128 model built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_ecb_dec;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] cipher_text = '0;
  logic [127:0] key = '0;
  logic [127:0] plain_text;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [256];

  ecb_dec dut (
    .clk         (clk),
    .rst         (rst),
    .cipher_text (cipher_text),
    .key         (key),
    .plain_text  (plain_text),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from the multiplicative inverse (x^254) followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      if (x != 0) begin
        inv = 8'h1;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sb[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
          s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One reset edge (outputs must clear), then release with the given vector.
  task automatic start(input logic [127:0] k, input logic [127:0] c);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pt", plain_text, 128'h0);
    chk("rst_done", {127'h0, done}, 128'h0);
    rst = 1'b0;
    key = k;
    cipher_text = c;
  endtask

  // Count edges after release until done; inputs scrambled after edge chg_edge if > 0.
  task automatic run(input logic [127:0] k, input logic [127:0] c, input int chg_edge,
                     output logic [127:0] res);
    int e = 0;
    start(k, c);
    while (e < 40) begin
      @(posedge clk); #1;
      e++;
      if (e == 1) begin
`ifdef ECB_DEC_MASK_OUT_EN
        chk("load_pt", plain_text, 128'h0);
`else
        chk("load_pt", plain_text, c);
`endif
      end
      if (e == chg_edge) begin
        key = rnd128();
        cipher_text = rnd128();
      end
      if (done) break;
    end
    chk("latency", 128'(e), 128'd22);
    res = plain_text;
  endtask

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] res, k, p;
    build_sbox();
    chk("model_appb", aes_enc(K_B, P_B), C_B);

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_rst_pt", plain_text, 128'h0);
      chk("hold_rst_done", {127'h0, done}, 128'h0);
    end

    run(K_C1, C_C1, 0, res);
    chk("c1_pt", res, P_C1);
    run(K_B, C_B, 0, res);
    chk("appb_pt", res, P_B);
    run(128'h0, C_Z, 0, res);
    chk("zero_pt", res, 128'h0);

    run(K_B, C_B, 4, res);
    chk("stable_pt", res, P_B);
    for (int i = 0; i < 100; i++) begin
      key = rnd128();
      cipher_text = rnd128();
      @(posedge clk); #1;
      chk("hold_pt", plain_text, P_B);
      chk("hold_done", {127'h0, done}, 128'h1);
    end

    // Abort at edge 10: nine edges into a C.1 run, then run() resets and checks zeros.
    start(K_C1, C_C1);
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1;
    run(K_B, C_B, 0, res);
    chk("abort_appb_pt", res, P_B);

    for (int n = 0; n < 16; n++) begin
      k = rnd128();
      p = rnd128();
      run(k, aes_enc(k, p), 0, res);
      chk("rand_pt", res, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
